terrain_probe_sequencer: RTL and testbench

Sequences all gameplay lookups into the single-port 128x128 course map BRAM. On each `start_in` pulse it reads five terrain probes around the ball: centre, right, left, up and down. It then publishes the terrain codes, per-side wall flags and an in-hole flag for the gameplay FSM. When it is not probing, it lends the BRAM port to one auxiliary requester (the minimap renderer) through a req/grant handshake.

---
 rtl/terrain_probe_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_terrain_probe_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/terrain_probe_sequencer.sv
// Five-point terrain probe around the ball through a shared single-port map BRAM,
// with an auxiliary reader served whenever the probe issue slots are not in use.
module terrain_probe_sequencer #(
  parameter int         WIDTH        = 128,
  parameter int         HEIGHT       = 128,
  parameter int         BALL_RADIUS  = 2,
  parameter int         READ_LATENCY = 2,
  parameter logic [1:0] WALL_CODE    = 2'd1,
  parameter logic [1:0] HOLE_CODE    = 2'd2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [15:0] pos_x_in,
  input  logic [15:0] pos_y_in,
  input  logic        aux_req_in,
  input  logic [15:0] aux_addr_in,
  output logic        aux_grant_out,
  output logic        aux_valid_out,
  output logic [1:0]  aux_data_out,
  output logic [15:0] bram_addr_out,
  input  logic [1:0]  bram_data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [1:0]  terrain_c_out,
  output logic [1:0]  terrain_r_out,
  output logic [1:0]  terrain_l_out,
  output logic [1:0]  terrain_u_out,
  output logic [1:0]  terrain_d_out,
  output logic        wall_r_out,
  output logic        wall_l_out,
  output logic        wall_u_out,
  output logic        wall_d_out,
  output logic        in_hole_out
);
  localparam int NPROBE = 5;
  localparam logic signed [9:0] W_S = 10'(WIDTH);
  localparam logic signed [9:0] H_S = 10'(HEIGHT);
  localparam logic signed [9:0] RAD = 10'(BALL_RADIUS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Probe k order: C, R, L, U, D. Returns {px, py} as signed 10-bit.
  function automatic logic [19:0] probe_xy(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] k);
    logic signed [9:0] px, py;
    px = signed'({2'b00, x});
    py = signed'({2'b00, y});
    case (k)
      3'd1:    px = px + RAD;
      3'd2:    px = px - RAD;
      3'd3:    py = py - RAD;
      3'd4:    py = py + RAD;
      default: ;
    endcase
    return {px, py};
  endfunction

  function automatic logic is_oob(input logic [19:0] xy);
    logic signed [9:0] px, py;
    px = signed'(xy[19:10]);
    py = signed'(xy[9:0]);
    return (px < 10'sd0) || (px >= W_S) || (py < 10'sd0) || (py >= H_S);
  endfunction

  function automatic logic [15:0] clamp_addr(input logic [19:0] xy);
    logic signed [9:0] px, py;
    logic [9:0] cx, cy;
    px = signed'(xy[19:10]);
    py = signed'(xy[9:0]);
    cx = (px < 10'sd0) ? 10'd0 : (px >= W_S) ? unsigned'(W_S - 10'sd1) : unsigned'(px);
    cy = (py < 10'sd0) ? 10'd0 : (py >= H_S) ? unsigned'(H_S - 10'sd1) : unsigned'(py);
    return 16'(32'(cy) * 32'(WIDTH) + 32'(cx));
  endfunction

  state_t                  state;
  logic [2:0]              idx;
  logic [7:0]              dcnt;
  logic [7:0]              xi, yi;
  logic [NPROBE-1:0]       oob_q, start_oob;
  logic [NPROBE-1:0][1:0]  res_q, res_nxt, pub_term, term_q;
  logic [3:0]              wall_q;
  logic                    hole_q, busy_q, done_q, issue;
  logic [READ_LATENCY:1]   probe_vld_pipe, aux_vld_pipe;
  logic [READ_LATENCY:1][2:0] probe_idx_pipe;
  logic                    unused_ok;

  assign issue         = (state == ISSUE);
  assign aux_grant_out = aux_req_in && !issue;
  assign bram_addr_out = aux_grant_out ? aux_addr_in :
                         issue         ? clamp_addr(probe_xy(xi, yi, idx)) : 16'd0;
  assign aux_valid_out = aux_vld_pipe[READ_LATENCY];
  assign aux_data_out  = aux_vld_pipe[READ_LATENCY] ? bram_data_in : 2'd0;
  assign unused_ok     = ^{pos_x_in[7:0], pos_y_in[7:0]};

  always_comb begin
    for (int k = 0; k < NPROBE; k++)
      start_oob[k] = is_oob(probe_xy(pos_x_in[15:8], pos_y_in[15:8], 3'(k)));
  end

  // Merge the returning read so the last probe can publish on the same edge it lands.
  always_comb begin
    res_nxt = res_q;
    if (probe_vld_pipe[READ_LATENCY] && probe_idx_pipe[READ_LATENCY] < 3'd5)
      res_nxt[probe_idx_pipe[READ_LATENCY]] = bram_data_in;
    for (int k = 0; k < NPROBE; k++)
      pub_term[k] = oob_q[k] ? WALL_CODE : res_nxt[k];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      idx            <= '0;
      dcnt           <= '0;
      xi             <= '0;
      yi             <= '0;
      oob_q          <= '0;
      res_q          <= '0;
      term_q         <= '0;
      wall_q         <= '0;
      hole_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      probe_vld_pipe <= '0;
      probe_idx_pipe <= '0;
      aux_vld_pipe   <= '0;
    end else begin
      res_q             <= res_nxt;
      probe_vld_pipe[1] <= issue;
      probe_idx_pipe[1] <= idx;
      aux_vld_pipe[1]   <= aux_grant_out;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        probe_vld_pipe[i] <= probe_vld_pipe[i-1];
        probe_idx_pipe[i] <= probe_idx_pipe[i-1];
        aux_vld_pipe[i]   <= aux_vld_pipe[i-1];
      end
      case (state)
        IDLE: if (start_in) begin
          xi     <= pos_x_in[15:8];
          yi     <= pos_y_in[15:8];
          oob_q  <= start_oob;
          idx    <= '0;
          busy_q <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          idx <= idx + 3'd1;
          if (idx == 3'(NPROBE - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 8'd1;
          if (dcnt == 8'(READ_LATENCY - 1)) begin
            term_q <= pub_term;
            wall_q <= {pub_term[4] == WALL_CODE, pub_term[3] == WALL_CODE,
                       pub_term[2] == WALL_CODE, pub_term[1] == WALL_CODE};
            hole_q <= (pub_term[0] == HOLE_CODE);
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign terrain_c_out = term_q[0];
  assign terrain_r_out = term_q[1];
  assign terrain_l_out = term_q[2];
  assign terrain_u_out = term_q[3];
  assign terrain_d_out = term_q[4];
  assign wall_r_out    = wall_q[0];
  assign wall_l_out    = wall_q[1];
  assign wall_u_out    = wall_q[2];
  assign wall_d_out    = wall_q[3];
  assign in_hole_out   = hole_q;
endmodule

// File: tb/tb_terrain_probe_sequencer.sv
// Directed bench for terrain_probe_sequencer: queued expected results, popped by a monitor.
module tb_terrain_probe_sequencer;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, start_in = 1'b0, aux_req_in = 1'b0;
  logic [15:0] pos_x_in = '0, pos_y_in = '0, aux_addr_in = '0;
  logic        aux_grant_out, aux_valid_out, busy_out, done_out, in_hole_out;
  logic [1:0]  aux_data_out, bram_data_in;
  logic [15:0] bram_addr_out;
  logic [1:0]  terrain_c_out, terrain_r_out, terrain_l_out, terrain_u_out, terrain_d_out;
  logic        wall_r_out, wall_l_out, wall_u_out, wall_d_out;

  terrain_probe_sequencer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .aux_req_in(aux_req_in), .aux_addr_in(aux_addr_in),
    .aux_grant_out(aux_grant_out), .aux_valid_out(aux_valid_out), .aux_data_out(aux_data_out),
    .bram_addr_out(bram_addr_out), .bram_data_in(bram_data_in),
    .busy_out(busy_out), .done_out(done_out),
    .terrain_c_out(terrain_c_out), .terrain_r_out(terrain_r_out), .terrain_l_out(terrain_l_out),
    .terrain_u_out(terrain_u_out), .terrain_d_out(terrain_d_out),
    .wall_r_out(wall_r_out), .wall_l_out(wall_l_out), .wall_u_out(wall_u_out),
    .wall_d_out(wall_d_out), .in_hole_out(in_hole_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle BRAM model
  logic [1:0]  mem [0:16383];
  logic [15:0] a1 = '0;
  logic [1:0]  dq = '0;
  always @(posedge clk_in) begin
    a1 <= bram_addr_out;
    dq <= mem[a1[13:0]];
  end
  assign bram_data_in = dq;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct { logic [14:0] res; int cyc; } exp_t;
  typedef struct { logic [1:0] d; int cyc; } aux_t;
  exp_t res_q[$];
  aux_t aux_q[$];
  exp_t me;
  aux_t ma;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input int c, r, l, u, d, wr, wl, wu, wd, h);
    return {c[1:0], r[1:0], l[1:0], u[1:0], d[1:0], wr[0], wl[0], wu[0], wd[0], h[0]};
  endfunction

  function automatic logic [14:0] got_res();
    return {terrain_c_out, terrain_r_out, terrain_l_out, terrain_u_out, terrain_d_out,
            wall_r_out, wall_l_out, wall_u_out, wall_d_out, in_hole_out};
  endfunction

  // Monitor
  always @(negedge clk_in) begin
    if (done_out) begin
      if (res_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = res_q.pop_front();
        chk("done_results", int'(got_res()), int'(me.res));
        chk("done_cycle", cyc, me.cyc);
      end
    end
    if (aux_valid_out) begin
      if (aux_q.size() == 0) chk("unexpected_aux_valid", 1, 0);
      else begin
        ma = aux_q.pop_front();
        chk("aux_data", int'(aux_data_out), int'(ma.d));
        chk("aux_cycle", cyc, ma.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic run_probe(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] a0, a1_, a2, a3, a4, input logic [14:0] er);
    logic [15:0] a [5];
    a = '{a0, a1_, a2, a3, a4};
    pos_x_in = x; pos_y_in = y; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    res_q.push_back('{er, cyc + 7});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("probe_addr", int'(bram_addr_out), int'(a[k]));
      chk("busy_issue", int'(busy_out), 1);
      tick();
    end
    repeat (6) tick();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 2'd0;
    #12;
    chk("reset_busy", int'(busy_out), 0);
    chk("reset_done", int'(done_out), 0);
    chk("reset_addr", int'(bram_addr_out), 0);
    chk("reset_results", int'(got_res()), 0);
    chk("reset_aux_valid", int'(aux_valid_out), 0);
    rst_n_in = 1'b1;
    tick();

    // Basic, all-zero map
    run_probe(16'h0A80, 16'h0A00, 16'd1290, 16'd1292, 16'd1288, 16'd1034, 16'd1546,
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Right wall and hole
    mem[1292] = 2'd1; mem[1290] = 2'd2;
    run_probe(16'h0A80, 16'h0A00, 16'd1290, 16'd1292, 16'd1288, 16'd1034, 16'd1546,
              mk(2, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    // Edge clamping: L and D out of bounds, L's clamped tile is not a wall in the map
    mem[16256] = 2'd3;
    run_probe(16'h0100, 16'h7F00, 16'd16257, 16'd16259, 16'd16256, 16'd16001, 16'd16257,
              mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0));

    // Arbitration: aux held through the sequence, start in the same cycle
    mem[500] = 2'd3;
    aux_req_in = 1'b1; aux_addr_in = 16'd500;
    pos_x_in = 16'h0A80; pos_y_in = 16'h0A00; start_in = 1'b1;
    @(negedge clk_in);
    chk("grant_t0", int'(aux_grant_out), 1);
    chk("aux_addr_t0", int'(bram_addr_out), 500);
    aux_q.push_back('{2'd3, cyc + 2});
    tick();
    start_in = 1'b0;
    res_q.push_back('{mk(2, 1, 0, 0, 0, 1, 0, 0, 0, 1), cyc + 7});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (k <= 5) begin
        chk("no_grant_issue", int'(aux_grant_out), 0);
      end else begin
        chk("grant_drain_done", int'(aux_grant_out), 1);
        chk("aux_addr_drain", int'(bram_addr_out), 500);
        aux_q.push_back('{2'd3, cyc + 2});
      end
      tick();
    end
    aux_req_in = 1'b0;
    repeat (6) tick();

    // Start while busy: second pulse at T3 ignored
    pos_x_in = 16'h0A80; pos_y_in = 16'h0A00; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    res_q.push_back('{mk(2, 1, 0, 0, 0, 1, 0, 0, 0, 1), cyc + 7});
    tick(); tick();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (12) tick();

    // Reset mid-sequence
    pos_x_in = 16'h0100; pos_y_in = 16'h7F00; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (3) tick();
    rst_n_in = 1'b0;
    #1;
    chk("midreset_busy", int'(busy_out), 0);
    chk("midreset_done", int'(done_out), 0);
    chk("midreset_addr", int'(bram_addr_out), 0);
    chk("midreset_results", int'(got_res()), 0);
    chk("midreset_aux_valid", int'(aux_valid_out), 0);
    tick(); tick();
    rst_n_in = 1'b1;
    repeat (10) tick();
    run_probe(16'h0100, 16'h7F00, 16'd16257, 16'd16259, 16'd16256, 16'd16001, 16'd16257,
              mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0));

    repeat (4) tick();
    chk("results_outstanding", res_q.size(), 0);
    chk("aux_outstanding", aux_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
